pipe_mem_stage: RTL and testbench

- EX/MEM pipeline register plus data-memory access controller for the pipelined MIPS core.
- Captures EX-stage results and drives a valid/ack data-memory bus.
- Stalls the front of the pipe while an access is outstanding.
- Presents RFWEM, MtoRFSelM, mem_read, ALU_outM and RtDM to the MEM/WB register (Pipe_WB), which has no stall input, so bubbles are inserted here.

---
 rtl/pipe_mem_stage.sv | 143 ++++++++++++++
 tb/tb_pipe_mem_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_stage.sv
// EX/MEM pipeline register and valid/ack data-memory access controller.
// Holds the front of the pipe while a load/store is outstanding on the memory bus.
//
// state  | meaning
// IDLE   | M holds a non-memory op or bubble; pipe advances every cycle
// ACCESS | aligned memory op in flight, dm_req high, pipe stalled
// DONE   | memory op finished (ack, timeout or misaligned); leaves M next edge
module pipe_mem_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RFWEE,
    input  logic        MtoRFSelE,
    input  logic        MemWEE,
    input  logic [31:0] ALU_outE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  RtDE,
    input  logic        FlushM,
    output logic        StallM,
    output logic        RFWEM,
    output logic        MtoRFSelM,
    output logic [31:0] ALU_outM,
    output logic [4:0]  RtDM,
    output logic [31:0] mem_read,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        dm_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] CNT_TC = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        rfwe_q, rfwe_d;
    logic        mtorfsel_q, mtorfsel_d;
    logic        memwe_q, memwe_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rtd_q, rtd_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    always_comb begin
        state_d    = state_q;
        rfwe_d     = rfwe_q;
        mtorfsel_d = mtorfsel_q;
        memwe_d    = memwe_q;
        alu_out_d  = alu_out_q;
        wdata_d    = wdata_q;
        rtd_d      = rtd_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        err_d      = err_q;

        if (state_q != ACCESS) begin
            if (FlushM) begin
                rfwe_d     = 1'b0;
                mtorfsel_d = 1'b0;
                memwe_d    = 1'b0;
                alu_out_d  = 32'd0;
                wdata_d    = 32'd0;
                rtd_d      = 5'd0;
            end else begin
                rfwe_d     = RFWEE;
                mtorfsel_d = MtoRFSelE;
                memwe_d    = MemWEE;
                alu_out_d  = ALU_outE;
                wdata_d    = WriteDataE;
                rtd_d      = RtDE;
            end
            // Misaligned ops never reach the bus; they complete immediately with an error.
            if (mtorfsel_d || memwe_d) begin
                if (alu_out_d[1:0] != 2'b00) begin
                    state_d = DONE;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    state_d = ACCESS;
                    cnt_d   = 8'd0;
                end
            end else begin
                state_d = IDLE;
            end
        end else begin
            if (dm_ack) begin
                rdata_d = mtorfsel_q ? dm_rdata : 32'd0;
                state_d = DONE;
            end else if (cnt_q == CNT_TC) begin
                rdata_d = 32'd0;
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            rfwe_q     <= 1'b0;
            mtorfsel_q <= 1'b0;
            memwe_q    <= 1'b0;
            alu_out_q  <= 32'd0;
            wdata_q    <= 32'd0;
            rtd_q      <= 5'd0;
            rdata_q    <= 32'd0;
            cnt_q      <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rfwe_q     <= rfwe_d;
            mtorfsel_q <= mtorfsel_d;
            memwe_q    <= memwe_d;
            alu_out_q  <= alu_out_d;
            wdata_q    <= wdata_d;
            rtd_q      <= rtd_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Pipe_WB cannot stall, so the write controls are masked to a bubble while waiting.
    assign StallM    = (state_q == ACCESS);
    assign RFWEM     = rfwe_q & ~StallM;
    assign MtoRFSelM = mtorfsel_q & ~StallM;
    assign ALU_outM  = alu_out_q;
    assign RtDM      = rtd_q;
    assign mem_read  = rdata_q;
    assign dm_req    = StallM;
    assign dm_we     = StallM & memwe_q;
    assign dm_addr   = StallM ? alu_out_q : 32'd0;
    assign dm_wdata  = StallM ? wdata_q : 32'd0;
    assign dm_err    = err_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed bench for pipe_mem_stage: per-cycle comparison against a transaction-level
// model of the M stage, plus literal expectations at key points of each scenario.
module tb_pipe_mem_stage;
    localparam int TIMEOUT = 4;

    logic        clk;
    logic        rst_n;
    logic        rfwe_e, ld_e, st_e, flush;
    logic [31:0] alu_e, wd_e;
    logic [4:0]  rt_e;
    logic        stall_m, rfwe_m, mtorf_m;
    logic [31:0] alu_m, mem_read;
    logic [4:0]  rt_m;
    logic        dm_req, dm_we, dm_ack, dm_err;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;

    int n_checks = 0;
    int n_errors = 0;

    pipe_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(clk), .RST_N(rst_n),
        .RFWEE(rfwe_e), .MtoRFSelE(ld_e), .MemWEE(st_e),
        .ALU_outE(alu_e), .WriteDataE(wd_e), .RtDE(rt_e), .FlushM(flush),
        .StallM(stall_m), .RFWEM(rfwe_m), .MtoRFSelM(mtorf_m),
        .ALU_outM(alu_m), .RtDM(rt_m), .mem_read(mem_read),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the instruction currently in M, whether it is still waiting on memory,
    // how long it has waited, the last access result and the sticky error.
    logic        m_rfwe, m_ld, m_st;
    logic [31:0] m_addr, m_wd, m_rdata;
    logic [4:0]  m_rt;
    logic        m_busy, m_err;
    int          m_wait;
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            {m_rfwe, m_ld, m_st} = 3'b000;
            m_addr = 0; m_wd = 0; m_rt = 0;
            m_busy = 0; m_wait = 0; m_rdata = 0; m_err = 0;
            started = 1'b1;
        end else if (started) begin
            if (m_busy) begin
                if (dm_ack) begin
                    m_rdata = m_ld ? dm_rdata : 32'd0;
                    m_busy = 0;
                end else if (m_wait + 1 == TIMEOUT) begin
                    m_rdata = 0; m_err = 1; m_busy = 0;
                end else begin
                    m_wait++;
                end
            end else begin
                if (flush) begin
                    {m_rfwe, m_ld, m_st} = 3'b000;
                    m_addr = 0; m_wd = 0; m_rt = 0;
                end else begin
                    m_rfwe = rfwe_e; m_ld = ld_e; m_st = st_e;
                    m_addr = alu_e; m_wd = wd_e; m_rt = rt_e;
                end
                if (m_ld || m_st) begin
                    if (m_addr % 4 != 0) begin
                        m_err = 1; m_rdata = 0;
                    end else begin
                        m_busy = 1; m_wait = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("m_stall", 32'(stall_m), 32'(m_busy));
            chk("m_rfwe", 32'(rfwe_m), 32'(m_rfwe & ~m_busy));
            chk("m_mtorf", 32'(mtorf_m), 32'(m_ld & ~m_busy));
            chk("m_alu", alu_m, m_addr);
            chk("m_rt", 32'(rt_m), 32'(m_rt));
            chk("m_mem_read", mem_read, m_rdata);
            chk("m_req", 32'(dm_req), 32'(m_busy));
            chk("m_we", 32'(dm_we), 32'(m_busy & m_st));
            chk("m_err", 32'(dm_err), 32'(m_err));
            if (m_busy) begin
                chk("m_addr", dm_addr, m_addr);
                chk("m_wdata", dm_wdata, m_wd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_e(input logic rfwe, input logic ld, input logic st,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rt);
        rfwe_e = rfwe; ld_e = ld; st_e = st; alu_e = addr; wd_e = wd; rt_e = rt;
    endtask

    initial begin
        // Reset with a load presented and dm_ack pulsed: reset must dominate.
        rst_n = 0; flush = 0; dm_ack = 1; dm_rdata = 32'hFFFF0000;
        set_e(1, 1, 0, 32'h40, 0, 7);
        tick(); tick();
        chk("rst_stall", 32'(stall_m), 0);
        chk("rst_rfwe", 32'(rfwe_m), 0);
        chk("rst_mtorf", 32'(mtorf_m), 0);
        chk("rst_alu", alu_m, 0);
        chk("rst_rt", 32'(rt_m), 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_req", 32'(dm_req), 0);
        chk("rst_we", 32'(dm_we), 0);
        chk("rst_err", 32'(dm_err), 0);

        rst_n = 1; dm_ack = 0;
        set_e(1, 0, 0, 32'h1234, 0, 5);
        tick();
        chk("alu_rfwe", 32'(rfwe_m), 1);
        chk("alu_val", alu_m, 32'h1234);
        chk("alu_rt", 32'(rt_m), 5);
        chk("alu_stall", 32'(stall_m), 0);
        chk("alu_req", 32'(dm_req), 0);

        // Load acknowledged in its third ACCESS cycle; flush during stall is ignored.
        set_e(1, 1, 0, 32'h40, 0, 8); dm_rdata = 32'hDEADBEEF;
        tick();
        chk("ld_stall1", 32'(stall_m), 1);
        chk("ld_req1", 32'(dm_req), 1);
        chk("ld_addr1", dm_addr, 32'h40);
        chk("ld_rfwe1", 32'(rfwe_m), 0);
        set_e(1, 0, 0, 32'h77, 0, 9); flush = 1;
        tick();
        chk("ld_stall2", 32'(stall_m), 1);
        chk("ld_alu2", alu_m, 32'h40);
        tick();
        chk("ld_stall3", 32'(stall_m), 1);
        chk("ld_rfwe3", 32'(rfwe_m), 0);
        flush = 0; dm_ack = 1;
        tick();
        chk("ld_done_stall", 32'(stall_m), 0);
        chk("ld_done_data", mem_read, 32'hDEADBEEF);
        chk("ld_done_rfwe", 32'(rfwe_m), 1);
        chk("ld_done_mtorf", 32'(mtorf_m), 1);
        dm_ack = 0;
        tick();
        chk("after_ld_rt", 32'(rt_m), 9);
        chk("after_ld_mtorf", 32'(mtorf_m), 0);

        // Flush while not stalled.
        set_e(1, 0, 0, 32'h99, 0, 3); flush = 1;
        tick();
        chk("flush_rfwe", 32'(rfwe_m), 0);
        chk("flush_rt", 32'(rt_m), 0);
        flush = 0;

        // Store then load back-to-back, ack held high.
        set_e(0, 0, 1, 32'h100, 32'hCAFEF00D, 0); dm_ack = 1;
        tick();
        chk("st_we", 32'(dm_we), 1);
        chk("st_wdata", dm_wdata, 32'hCAFEF00D);
        chk("st_addr", dm_addr, 32'h100);
        set_e(1, 1, 0, 32'h104, 0, 10); dm_rdata = 32'h11112222;
        tick();
        chk("st_done_stall", 32'(stall_m), 0);
        chk("st_done_data", mem_read, 0);
        tick();
        chk("ld2_req", 32'(dm_req), 1);
        chk("ld2_we", 32'(dm_we), 0);
        chk("ld2_addr", dm_addr, 32'h104);
        set_e(0, 0, 0, 0, 0, 0);
        tick();
        chk("ld2_data", mem_read, 32'h11112222);
        chk("ld2_rt", 32'(rt_m), 10);
        dm_ack = 0;
        tick();

        // Timeout after TIMEOUT cycles without ack.
        set_e(1, 1, 0, 32'h200, 0, 11);
        tick();
        set_e(0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        chk("to_stall4", 32'(stall_m), 1);
        chk("to_err4", 32'(dm_err), 0);
        tick();
        chk("to_err", 32'(dm_err), 1);
        chk("to_data", mem_read, 0);
        chk("to_stall", 32'(stall_m), 0);
        dm_ack = 1;
        tick();
        chk("late_ack_stall", 32'(stall_m), 0);
        dm_ack = 0;

        rst_n = 0;
        tick();
        rst_n = 1;
        chk("err_cleared", 32'(dm_err), 0);

        // Good load, then misaligned load straight out of DONE.
        set_e(1, 1, 0, 32'h80, 0, 12); dm_rdata = 32'h55AA55AA; dm_ack = 1;
        tick(); tick();
        chk("al_data", mem_read, 32'h55AA55AA);
        set_e(1, 1, 0, 32'h42, 0, 13); dm_ack = 0;
        tick();
        chk("mis_req", 32'(dm_req), 0);
        chk("mis_err", 32'(dm_err), 1);
        chk("mis_data", mem_read, 0);
        set_e(0, 0, 0, 0, 0, 0);
        tick();
        chk("mis_req2", 32'(dm_req), 0);

        // Reset in the middle of an access; a later ack must be ignored.
        set_e(1, 1, 0, 32'h300, 0, 14);
        tick();
        chk("mid_req", 32'(dm_req), 1);
        rst_n = 0;
        tick();
        chk("mid_rst_req", 32'(dm_req), 0);
        chk("mid_rst_stall", 32'(stall_m), 0);
        rst_n = 1; dm_ack = 1; dm_rdata = 32'h0000ABCD;
        set_e(0, 0, 0, 0, 0, 0);
        tick();
        chk("mid_ack_data", mem_read, 0);
        chk("mid_ack_stall", 32'(stall_m), 0);
        dm_ack = 0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
